// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate L1 data cache.
// Read hits complete combinationally. Misses refill the whole line from word 0 upward.
// Stores always write through, and they update the line only when it is resident.
module data_cache #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic [31:0] i_address,
  input  logic        i_read,
  input  logic        i_write,
  inout  wire  [31:0] io_data,
  output logic        o_hit,
  output logic [31:0] o_mem_address,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic [31:0] o_mem_data,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_ready
);

  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   beat_q, beat_d;
  logic [29:0]        addr_q, addr_d;    // latched word address
  logic [31:0]        wdata_q, wdata_d;
  logic [LINES-1:0]   valid_q, valid_d;

  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*WORDS_PER_LINE];

  // Request-side address fields
  logic [OFF_W-1:0]   req_off;
  logic [IDX_W-1:0]   req_idx;
  logic [TAG_W-1:0]   req_tag;
  assign req_off = i_address[OFF_W+1:2];
  assign req_idx = i_address[OFF_W+IDX_W+1:OFF_W+2];
  assign req_tag = i_address[31:OFF_W+IDX_W+2];

  // Latched address fields
  logic [OFF_W-1:0]   lat_off;
  logic [IDX_W-1:0]   lat_idx;
  logic [TAG_W-1:0]   lat_tag;
  assign lat_off = addr_q[OFF_W-1:0];
  assign lat_idx = addr_q[OFF_W+IDX_W-1:OFF_W];
  assign lat_tag = addr_q[29:OFF_W+IDX_W];

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^i_address[1:0];

  logic req_hit, wr_hit, last_beat;
  assign req_hit   = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign wr_hit    = valid_q[lat_idx] && (tag_mem[lat_idx] == lat_tag);
  assign last_beat = (beat_q == '1);

  logic [31:0] rd_word;
  assign rd_word = data_mem[{req_idx, req_off}];

  // Load data goes onto the shared bus only while a load is completing
  assign io_data = (i_read && o_hit) ? rd_word : 'z;

  // Control state register and valid bits
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; residency is governed by valid_q alone
  always_ff @(posedge i_clock) begin
    if (state_q == REFILL && i_mem_ready) begin
      data_mem[{lat_idx, beat_q}] <= i_mem_data;
      if (last_beat) tag_mem[lat_idx] <= lat_tag;
    end
    if (state_q == WRITE && i_mem_ready && wr_hit) begin
      data_mem[{lat_idx, lat_off}] <= wdata_q;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (i_write) begin
          addr_d  = i_address[31:2];
          wdata_d = io_data;
          state_d = WRITE;
        end else if (i_read && !req_hit) begin
          addr_d           = i_address[31:2];
          beat_d           = '0;
          // The victim line is overwritten beat by beat, so it stops being resident now
          valid_d[req_idx] = 1'b0;
          state_d          = REFILL;
        end
      end
      REFILL: begin
        if (i_mem_ready) begin
          beat_d = beat_q + OFF_W'(1);
          if (last_beat) begin
            valid_d[lat_idx] = 1'b1;
            state_d          = IDLE;
          end
        end
      end
      WRITE: begin
        if (i_mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_hit         = 1'b0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_mem_address = '0;
    o_mem_data    = '0;
    case (state_q)
      IDLE: begin
        o_hit = i_read && !i_write && req_hit;
      end
      REFILL: begin
        o_mem_read    = 1'b1;
        o_mem_address = {lat_tag, lat_idx, beat_q, 2'b00};
      end
      WRITE: begin
        o_mem_write   = 1'b1;
        o_mem_address = {addr_q, 2'b00};
        o_mem_data    = wdata_q;
        o_hit         = i_mem_ready;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: memory model plus scoreboard queues of
// expected load data and expected refill beat addresses.
module tb_data_cache;

  logic        clk;
  logic        i_reset_n;
  logic [31:0] i_address;
  logic        i_read;
  logic        i_write;
  wire  [31:0] io_data;
  logic        o_hit;
  logic [31:0] o_mem_address;
  logic        o_mem_read;
  logic        o_mem_write;
  logic [31:0] o_mem_data;
  logic [31:0] i_mem_data;
  logic        i_mem_ready;

  logic        tb_drv;
  logic [31:0] tb_wdata;
  assign io_data = tb_drv ? tb_wdata : 'z;

  data_cache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .i_clock       (clk),
    .i_reset_n     (i_reset_n),
    .i_address     (i_address),
    .i_read        (i_read),
    .i_write       (i_write),
    .io_data       (io_data),
    .o_hit         (o_hit),
    .o_mem_address (o_mem_address),
    .o_mem_read    (o_mem_read),
    .o_mem_write   (o_mem_write),
    .o_mem_data    (o_mem_data),
    .i_mem_data    (i_mem_data),
    .i_mem_ready   (i_mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] rd_q [$];
  logic [31:0] mem_q [$];

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_checks++;
    n_fails++;
    $error("FAIL %s: observed event missing expected event present", tag);
  endtask

  // Accepted refill beat: compare against the next expected beat address
  task automatic pop_beat(input string tag);
    if (mem_q.size() == 0) fail_now({tag, "_unexpected_beat"});
    else check({tag, "_beat_addr"}, o_mem_address, mem_q.pop_front());
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input bit miss,
                         input int lat, input bit stall);
    int  c;
    int  nb;
    bit  done;
    rd_q.push_back(memval(a));
    if (miss)
      for (int unsigned b = 0; b < 4; b++) mem_q.push_back((a & ~32'hF) + 32'(b * 4));
    i_address = a;
    i_read    = 1'b1;
    c = 0; nb = 0; done = 1'b0;
    while (!done && c < 40) begin
      i_mem_ready = stall ? (c % 2 == 0) : 1'b1;
      i_mem_data  = memval(o_mem_address);
      @(negedge clk);
      if (o_mem_read) begin
        check({tag, "_excl"}, 32'(o_mem_write), 32'd0);
        if (i_mem_ready) begin
          pop_beat(tag);
          nb++;
        end else if (mem_q.size() != 0) begin
          check({tag, "_stall_addr"}, o_mem_address, mem_q[0]);
        end
      end
      if (o_hit) begin
        if (rd_q.size() == 0) fail_now({tag, "_unexpected_hit"});
        else check({tag, "_data"}, io_data, rd_q.pop_front());
        check({tag, "_latency"}, 32'(c), 32'(lat));
        check({tag, "_beats"}, 32'(nb), miss ? 32'd4 : 32'd0);
        done = 1'b1;
      end
      @(posedge clk); #1;
      c++;
    end
    if (!done) fail_now({tag, "_timeout"});
    i_read      = 1'b0;
    i_mem_ready = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input int delay);
    int c;
    int nw;
    bit done;
    i_address = a;
    i_write   = 1'b1;
    tb_wdata  = d;
    tb_drv    = 1'b1;
    c = 0; nw = 0; done = 1'b0;
    while (!done && c < 40) begin
      i_mem_ready = (c >= delay);
      @(negedge clk);
      if (o_mem_write) begin
        nw++;
        check({tag, "_excl"}, 32'(o_mem_read), 32'd0);
        check({tag, "_wr_addr"}, o_mem_address, a & ~32'h3);
        check({tag, "_wr_data"}, o_mem_data, d);
      end
      if (o_hit) begin
        check({tag, "_hit_cycle"}, 32'(c), 32'(delay));
        check({tag, "_wr_cycles"}, 32'(nw), 32'(delay));
        mem[a & ~32'h3] = d;
        done = 1'b1;
      end
      @(posedge clk); #1;
      c++;
    end
    if (!done) fail_now({tag, "_timeout"});
    i_write     = 1'b0;
    tb_drv      = 1'b0;
    i_mem_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    i_reset_n   = 1'b0;
    i_address   = 32'h40;
    i_read      = 1'b1;
    i_write     = 1'b0;
    i_mem_data  = '0;
    i_mem_ready = 1'b1;
    tb_drv      = 1'b0;
    tb_wdata    = '0;
    mem[32'h40] = 32'h11;
    mem[32'h44] = 32'h22;
    mem[32'h48] = 32'h33;
    mem[32'h4C] = 32'h44;

    // Reset state, with a read pending so nothing may hit or request memory
    repeat (2) @(negedge clk);
    check("rst_hit",      32'(o_hit),       32'd0);
    check("rst_mem_read", 32'(o_mem_read),  32'd0);
    check("rst_mem_wr",   32'(o_mem_write), 32'd0);
    check("rst_mem_addr", o_mem_address,    32'd0);
    check("rst_mem_data", o_mem_data,       32'd0);
    i_reset_n = 1'b1;
    i_read    = 1'b0;
    @(posedge clk); #1;

    do_read("miss40", 32'h40, 1'b1, 5, 1'b0);
    do_read("hit48",  32'h48, 1'b0, 0, 1'b0);

    do_write("st44", 32'h44, 32'hDEAD_BEEF, 3);
    do_read("hit44_new", 32'h44, 1'b0, 0, 1'b0);

    do_write("st1000", 32'h1000, 32'h1234_5678, 1);
    @(negedge clk);
    check("st1000_pulse_end", 32'(o_hit),       32'd0);
    check("st1000_idle_wr",   32'(o_mem_write), 32'd0);
    @(posedge clk); #1;
    do_read("miss1000", 32'h1000, 1'b1, 5, 1'b0);

    do_read("miss140",    32'h140, 1'b1, 5, 1'b0);
    do_read("remiss40",   32'h40,  1'b1, 5, 1'b0);
    do_read("hit44_back", 32'h44,  1'b0, 0, 1'b0);

    do_read("stall300", 32'h300, 1'b1, 9, 1'b0 | 1'b1);

    // Reset lands after the second beat of a refill
    mem_q.push_back(32'h200);
    mem_q.push_back(32'h204);
    i_address   = 32'h200;
    i_read      = 1'b1;
    i_mem_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 10 && nb < 2; c++) begin
      i_mem_data = memval(o_mem_address);
      @(negedge clk);
      if (o_mem_read) begin
        pop_beat("abort200");
        nb++;
      end
      @(posedge clk); #1;
    end
    check("abort200_beats", 32'(nb), 32'd2);
    i_reset_n   = 1'b0;
    i_read      = 1'b0;
    i_mem_ready = 1'b0;
    @(negedge clk);
    check("abort_hit",      32'(o_hit),       32'd0);
    check("abort_mem_read", 32'(o_mem_read),  32'd0);
    check("abort_mem_wr",   32'(o_mem_write), 32'd0);
    check("abort_mem_addr", o_mem_address,    32'd0);
    check("abort_mem_data", o_mem_data,       32'd0);
    i_reset_n = 1'b1;
    @(posedge clk); #1;
    do_read("refill200", 32'h200, 1'b1, 5, 1'b0);

    check("leftover_beats", 32'(mem_q.size()), 32'd0);
    check("leftover_reads", 32'(rd_q.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-through, no-write-allocate L1 data cache. It is the responder side of the load/store-unit cache interface: it accepts word read/write requests from the load/store combo, answers hits, and signals completion through `o_hit`. It refills lines from, and writes through to, the memory-side port. It sits between the load/store combo and the memory arbiter.

## Interface
- `LINES`, 16: number of lines; power of two, ≥2.
- `WORDS_PER_LINE`, 4: 32-bit words per line; power of two, ≥2.
- `i_clock`  in  1  system clock, rising edge.
- `i_reset_n`  in  1  asynchronous active-low reset.
- `i_address`  in  32  byte address from load/store unit; bits [1:0] ignored.
- `i_read`  in  1  load request; held stable until `o_hit`.
- `i_write`  in  1  store request; held stable with address/data until `o_hit`.
- `io_data`  inout  32  store data in; load data out. Cache drives it only while `i_read && o_hit`, otherwise high-Z.
- `o_hit`  out  1  request complete (load data valid / store accepted).
- `o_mem_address`  out  32  memory word address, bits [1:0] = 0.
- `o_mem_read`  out  1  refill beat request.
- `o_mem_write`  out  1  write-through request.
- `o_mem_data`  out  32  write-through data.
- `i_mem_data`  in  32  refill data, valid with `i_mem_ready`.
- `i_mem_ready`  in  1  memory accepted write / returned read beat this cycle.

## Operation
- Address split: offset = addr[log2(WORDS_PER_LINE)+1:2], index = next log2(LINES) bits, tag = the remaining upper bits.
- Storage: data array, tag array, and valid bit per line. Only the valid bits are reset.
- FSM states: IDLE, REFILL, WRITE.
- IDLE, `i_write` set: latch address and data, go to WRITE. Write has priority if `i_read` and `i_write` are both set; that case is illegal from the requester.
- IDLE, `i_read` set:
  - Valid and tag match: `o_hit`=1 combinationally, `io_data` = cached word.
  - Otherwise: latch the line address, clear the beat counter, go to REFILL. `o_hit`=0.
- REFILL:
  - Drive `o_mem_read`=1 and `o_mem_address` = {latched tag, index, beat, 2'b00}.
  - Each cycle with `i_mem_ready`: write `i_mem_data` into word[beat] and increment beat.
  - On the last beat (WORDS_PER_LINE-1): set the valid bit, write the tag, go to IDLE. The request then hits from IDLE.
  - Beats are fetched from word 0 upward; there is no critical-word-first.
  - If the requester drops `i_read` mid-refill, the refill still completes and the line is installed.
- WRITE:
  - Drive `o_mem_write`=1, `o_mem_address` = latched word address, `o_mem_data` = latched data.
  - On `i_mem_ready`: `o_hit`=1 for that cycle. If the line is valid and the tag matches, update the cached word in the same edge. Go to IDLE.
  - A write miss does not allocate.
- `o_mem_read` and `o_mem_write` are never both high.
- Reset mid-refill: the partial line stays invalid and the FSM returns to IDLE.

## Timing
- Reset values: state IDLE, all valid bits 0, beat counter 0, `o_hit`=0, `o_mem_read`=0, `o_mem_write`=0, `o_mem_address`=0, `o_mem_data`=0, `io_data` high-Z.
- Read hit: 0-cycle latency. `o_hit` is asserted in the cycle `i_read` is presented in IDLE, and stays high while the request is held.
- Read miss with `i_mem_ready` constantly high:
  - Request at cycle 0.
  - REFILL during cycles 1..WORDS_PER_LINE.
  - `o_hit` at cycle WORDS_PER_LINE+1.
- Memory stalls (`i_mem_ready`=0) hold the beat and address unchanged.
- Store: request at cycle 0, WRITE from cycle 1. `o_hit` is a single-cycle pulse in the cycle `i_mem_ready` is seen, earliest cycle 1.
- The requester deasserts `i_write` in the cycle after the `o_hit` pulse. A store still held in IDLE is treated as a new store.
- A read after a store to the same word, issued the cycle after `o_hit`, returns the new data.

## Test plan
- Reset, then read 0x0000_0040 with memory returning 0x11,0x22,0x33,0x44 and ready always high -> `o_mem_read` for 4 cycles at addresses 0x40,0x44,0x48,0x4C; `o_hit` at cycle 5; `io_data`=0x11.
- After the above, read 0x48 -> `o_hit` in the same cycle, `io_data`=0x33, no memory traffic.
- Store 0xDEAD_BEEF to 0x44 with `i_mem_ready` delayed 3 cycles -> `o_mem_write` high for 3 cycles, `o_hit` pulse on the ready cycle. A following read of 0x44 hits and returns 0xDEAD_BEEF.
- Store to uncached 0x1000 -> write-through only. A following read of 0x1000 misses and refills.
- Conflict eviction: with LINES=16 and 16-byte lines, read 0x40 then 0x140 (same index) -> the second access refills. A re-read of 0x40 misses again.
- Assert `i_reset_n`=0 after the 2nd refill beat -> outputs return to reset values. A subsequent read of the same address performs a full 4-beat refill.
